// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, one full-subtractor cell, LSB first
//
// Computes diff = a - b - borrow_in (unsigned, modulo 2^NUM_BITS) over NUM_BITS
// clock cycles using one full-subtractor cell and a borrow flip-flop.
//
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous reset, active-high
//   start      in   1         request; operands sampled on the accepting edge
//   a          in   NUM_BITS  minuend
//   b          in   NUM_BITS  subtrahend
//   borrow_in  in   1         initial borrow
//   busy       out  1         high while a subtraction is in progress
//   done       out  1         one-cycle pulse: diff/underflow just updated
//   diff       out  NUM_BITS  result (a - b - borrow_in) mod 2^NUM_BITS
//   underflow  out  1         final borrow out (1 = a < b + borrow_in)

module serial_subtractor #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                underflow
);

    localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                load;
    logic                last_bit;

    logic [NUM_BITS-1:0] a_sr;
    logic [NUM_BITS-1:0] b_sr;
    logic [NUM_BITS-1:0] res_sr;
    logic                br;
    logic [CW-1:0]       cnt;

    logic                d_bit;
    logic                br_nxt;
    logic [NUM_BITS-1:0] res_nxt;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    assign d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_nxt = {d_bit, res_sr[NUM_BITS-1:1]};

    assign last_bit = (cnt == CW'(NUM_BITS - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A start here is accepted immediately for back-to-back operation.
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            underflow <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= borrow_in;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            br     <= br_nxt;
            cnt    <= cnt + CW'(1);
            // The final bit is folded in on the same edge that enters DONE, so the
            // outputs are already valid during the single done cycle.
            if (last_bit) begin
                diff      <= res_nxt;
                underflow <= br_nxt;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of serial_subtractor

module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        borrow_in;
    logic        busy;
    logic        done;
    logic [3:0]  diff;
    logic        underflow;

    logic        w_start;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic        w_borrow_in;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_diff;
    logic        w_underflow;

    int checks;
    int errors;
    logic [3:0]  last4;
    logic        last4_uf;
    logic [15:0] last16;
    logic        last16_uf;

    serial_subtractor #(.NUM_BITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .underflow (underflow)
    );

    serial_subtractor #(.NUM_BITS(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .a         (w_a),
        .b         (w_b),
        .borrow_in (w_borrow_in),
        .busy      (w_busy),
        .done      (w_done),
        .diff      (w_diff),
        .underflow (w_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tbi, input string tag);
        logic [4:0] e;
        e = {1'b0, ta} - {1'b0, tb_} - {4'b0, tbi};
        start = 1'b1; a = ta; b = tb_; borrow_in = tbi;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " busy"}, busy, 1'b1);
            chk({tag, " done_low"}, done, 1'b0);
            chk({tag, " diff_hold"}, diff, last4);
            @(negedge clk);
        end
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " busy_low"}, busy, 1'b0);
        chk({tag, " diff"}, diff, e[3:0]);
        chk({tag, " underflow"}, underflow, e[4]);
        last4 = e[3:0];
        last4_uf = e[4];
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tbi);
        logic [16:0] e;
        e = {1'b0, ta} - {1'b0, tb_} - {16'b0, tbi};
        w_start = 1'b1; w_a = ta; w_b = tb_; w_borrow_in = tbi;
        @(posedge clk);
        @(negedge clk);
        w_start = 1'b0;
        w_a = 16'($urandom); w_b = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) chk("w16 busy", w_busy, 1'b1);
            @(negedge clk);
        end
        chk("w16 done", w_done, 1'b1);
        chk("w16 diff", w_diff, e[15:0]);
        chk("w16 underflow", w_underflow, e[16]);
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        last4 = 4'd0; last4_uf = 1'b0; last16 = 16'd0; last16_uf = 1'b0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        w_start = 1'b0; w_a = '0; w_b = '0; w_borrow_in = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset diff", diff, 4'd0);
        chk("reset underflow", underflow, 1'b0);
        chk("reset w16 busy", w_busy, 1'b0);
        chk("reset w16 diff", w_diff, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        run4(4'd7, 4'd3, 1'b0, "t1 7-3");
        @(negedge clk);
        chk("t1 idle done", done, 1'b0);
        run4(4'd3, 4'd7, 1'b0, "t2 3-7");
        @(negedge clk);
        run4(4'd0, 4'd0, 1'b1, "t2 0-0-1");
        @(negedge clk);
        run4(4'd15, 4'd15, 1'b0, "t2 15-15");
        @(negedge clk);

        // start held high, operands scrambled during SHIFT
        start = 1'b1; a = 4'd10; b = 4'd4; borrow_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom); b = 4'($urandom); borrow_in = 1'($urandom);
            chk("t3 busy", busy, 1'b1);
            chk("t3 done_low", done, 1'b0);
            chk("t3 diff_hold", diff, last4);
            @(negedge clk);
        end
        chk("t3 done", done, 1'b1);
        chk("t3 diff", diff, 4'd6);
        chk("t3 underflow", underflow, 1'b0);
        last4 = 4'd6; last4_uf = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("t3 idle busy", busy, 1'b0);
        chk("t3 idle done", done, 1'b0);

        // back-to-back: second start issued in the done cycle
        run4(4'd8, 4'd3, 1'b0, "t4 8-3");
        run4(4'd9, 4'd2, 1'b0, "t4 9-2");
        @(negedge clk);
        chk("t4 idle done", done, 1'b0);
        chk("t4 idle busy", busy, 1'b0);

        // asynchronous reset mid-SHIFT
        run4(4'd13, 4'd2, 1'b0, "t5 pre");
        @(negedge clk);
        start = 1'b1; a = 4'd5; b = 4'd1; borrow_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5 rst busy", busy, 1'b0);
        chk("t5 rst done", done, 1'b0);
        chk("t5 rst diff", diff, 4'd0);
        chk("t5 rst underflow", underflow, 1'b0);
        last4 = 4'd0; last4_uf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5 no_done", done, 1'b0);
            chk("t5 no_busy", busy, 1'b0);
        end
        run4(4'd6, 4'd9, 1'b1, "t5 post 6-9-1");
        @(negedge clk);

        // exhaustive 4-bit, back-to-back
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run4(4'(ia), 4'(ib), 1'(ic), "t6 exh");
                end
            end
        end
        @(negedge clk);

        // 16-bit random plus corner values
        run16(16'h0000, 16'h0000, 1'b1);
        run16(16'hFFFF, 16'hFFFF, 1'b0);
        run16(16'h8000, 16'h0001, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
